// File: rtl/niosii_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// Word address is {channel, reg[2:0]}.
interface niosii_multi_timer_if #(
  parameter int NUM_CH = 4
) ();
  localparam int AW = 3 + $clog2(NUM_CH);

  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/niosii_multi_timer.sv
// Multi-channel Avalon-MM interval timer. Each channel is a prescaled
// down-counter with one-shot/continuous mode, compare-based PWM and a
// snapshot register. Channel IRQs (TO & ITO) are exported as a vector and
// ORed onto a single irq line.
module niosii_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                      clk,
  input  logic                      reset_n,
  niosii_multi_timer_if.slave       bus,
  output logic                      irq,
  output logic [NUM_CH-1:0]         irq_vec,
  output logic [NUM_CH-1:0]         pwm_out
);
  localparam int AW = 3 + $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] RST_PER = CNT_W'(RESET_PERIOD);

  localparam logic [2:0] R_STATUS   = 3'd0;
  localparam logic [2:0] R_CONTROL  = 3'd1;
  localparam logic [2:0] R_PERIOD   = 3'd2;
  localparam logic [2:0] R_COMPARE  = 3'd3;
  localparam logic [2:0] R_SNAP     = 3'd4;
  localparam logic [2:0] R_PRESCALE = 3'd5;

  logic                     wr_en;
  logic [2:0]               reg_sel;
  logic [3:0]               ch_idx;
  logic [NUM_CH-1:0][31:0]  ch_rd;
  logic [31:0]              rd_next;
  logic [31:0]              readdata_q;

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign reg_sel = bus.address[2:0];

  // A single-channel build has no channel field in the address.
  if (NUM_CH > 1) begin : g_ch_idx
    assign ch_idx = 4'(bus.address[AW-1:3]);
  end else begin : g_ch_idx1
    assign ch_idx = 4'd0;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    logic              wr_hit;
    logic              tick;
    logic              timeout;
    logic              to_q, run_q, ito_q, cont_q, pwm_en_q;
    logic              load_q;
    logic              pwm_q;
    logic [CNT_W-1:0]  period_q, cmp_q, snap_q, cnt_q;
    logic [PRE_W-1:0]  pre_q, pcnt_q;
    logic [31:0]       rd_word;

    assign wr_hit  = wr_en && (ch_idx == 4'(c));
    assign tick    = run_q && (pcnt_q == pre_q);
    assign timeout = tick && (cnt_q == '0);

    // Channel state: prescaler, counter, control/status and register writes.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        to_q     <= 1'b0;
        run_q    <= 1'b0;
        ito_q    <= 1'b0;
        cont_q   <= 1'b0;
        pwm_en_q <= 1'b0;
        load_q   <= 1'b0;
        pwm_q    <= 1'b0;
        period_q <= RST_PER;
        cnt_q    <= RST_PER;
        cmp_q    <= '0;
        snap_q   <= '0;
        pre_q    <= '0;
        pcnt_q   <= '0;
      end else begin
        // Prescaler only advances while running; a pending reload also restarts it.
        if (!run_q || tick || load_q) pcnt_q <= '0;
        else                          pcnt_q <= pcnt_q + 1'b1;

        // A PERIOD write reloads the counter one edge after the write.
        load_q <= 1'b0;
        if (load_q)
          cnt_q <= period_q;
        else if (tick)
          cnt_q <= (cnt_q == '0) ? period_q : cnt_q - 1'b1;

        if (timeout) begin
          to_q <= 1'b1;
          if (!cont_q) run_q <= 1'b0;
        end

        if (wr_hit) begin
          case (reg_sel)
            // A clear coinciding with a timeout must not lose the event.
            R_STATUS:  if (!timeout) to_q <= 1'b0;
            R_CONTROL: begin
              ito_q    <= bus.writedata[0];
              cont_q   <= bus.writedata[1];
              pwm_en_q <= bus.writedata[4];
              if (bus.writedata[3])      run_q <= 1'b0;
              else if (bus.writedata[2]) run_q <= 1'b1;
            end
            R_PERIOD: begin
              period_q <= bus.writedata[CNT_W-1:0];
              run_q    <= 1'b0;
              load_q   <= 1'b1;
            end
            R_COMPARE:  cmp_q  <= bus.writedata[CNT_W-1:0];
            R_SNAP:     snap_q <= cnt_q;
            R_PRESCALE: pre_q  <= bus.writedata[PRE_W-1:0];
            default: ;
          endcase
        end

        pwm_q <= pwm_en_q & run_q & (cnt_q < cmp_q);
      end
    end

    // Per-channel register readback, zero-extended to the bus width.
    always_comb begin
      rd_word = '0;
      case (reg_sel)
        R_STATUS:   rd_word = {30'd0, run_q, to_q};
        R_CONTROL:  rd_word = {27'd0, pwm_en_q, 2'b00, cont_q, ito_q};
        R_PERIOD:   rd_word = 32'(period_q);
        R_COMPARE:  rd_word = 32'(cmp_q);
        R_SNAP:     rd_word = 32'(snap_q);
        R_PRESCALE: rd_word = 32'(pre_q);
        default:    rd_word = '0;
      endcase
    end

    assign ch_rd[c]   = rd_word;
    assign irq_vec[c] = to_q & ito_q;
    assign pwm_out[c] = pwm_q;
  end

  assign irq = |irq_vec;

  // Channel select for the read path; unpopulated channel slots read 0.
  always_comb begin
    rd_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == 4'(c)) rd_next = ch_rd[c];
    end
  end

  // Registered read data, updated every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= rd_next;
  end

  assign bus.readdata = readdata_q;
endmodule

// File: tb/tb_niosii_multi_timer.sv
// Directed bench for niosii_multi_timer. Three channels are instantiated so
// that channel slot 3 exists in the address space but is unpopulated.
// All bus activity and sampling happen on the falling clock edge.
module tb_niosii_multi_timer;
  localparam int NUM_CH = 3;
  localparam int AW     = 3 + $clog2(NUM_CH);

  localparam int R_STATUS   = 0;
  localparam int R_CONTROL  = 1;
  localparam int R_PERIOD   = 2;
  localparam int R_COMPARE  = 3;
  localparam int R_SNAP     = 4;
  localparam int R_PRESCALE = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;
  logic [NUM_CH-1:0] pwm_out;

  int n_cmp = 0;
  int n_bad = 0;

  niosii_multi_timer_if #(.NUM_CH(NUM_CH)) bus ();

  niosii_multi_timer #(.NUM_CH(NUM_CH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq),
    .irq_vec (irq_vec),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; the write is sampled on the next rising edge.
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    bus.address    = AW'(ch * 8 + r);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] d);
    bus.address = AW'(ch * 8 + r);
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_pwm(input int ch, input int n, output int k);
    k = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out[ch]) k++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          k;

    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    reset_n        = 1'b0;
    idle(2);
    chk("rst_irq",  32'(irq),     32'd0);
    chk("rst_vec",  32'(irq_vec), 32'd0);
    chk("rst_pwm",  32'(pwm_out), 32'd0);
    chk("rst_rdata", bus.readdata, 32'd0);
    reset_n = 1'b1;
    idle(1);
    rd(0, R_PERIOD, d);  chk("rst_period", d, 32'd49999);
    rd(0, R_CONTROL, d); chk("rst_control", d, 32'd0);

    // Continuous ch0, PERIOD=4: timeouts every 5 clocks after START.
    wr(0, R_PERIOD, 32'd4);
    idle(1);
    wr(0, R_CONTROL, 32'h7);
    idle(4); chk("t1_irq_before", 32'(irq), 32'd0);
    idle(1); chk("t1_irq_first", 32'(irq), 32'd1);
    wr(0, R_STATUS, 32'd0);
    chk("t1_irq_cleared", 32'(irq), 32'd0);
    idle(3); chk("t1_irq_gap", 32'(irq), 32'd0);
    idle(1); chk("t1_irq_second", 32'(irq), 32'd1);
    rd(0, R_STATUS, d); chk("t1_status_run", d, 32'd3);

    // Clear coinciding with the third timeout leaves TO set.
    wr(0, R_STATUS, 32'd0);
    chk("t4_irq_cleared", 32'(irq), 32'd0);
    idle(2);
    wr(0, R_STATUS, 32'd0);
    chk("t4_irq_kept", 32'(irq), 32'd1);
    rd(0, R_STATUS, d); chk("t4_status_kept", d, 32'd3);
    // START|STOP together: stop wins, counter frozen at 2.
    wr(0, R_CONTROL, 32'hC);
    chk("t4_irq_ito_off", 32'(irq), 32'd0);
    rd(0, R_STATUS, d); chk("t4_status_stopped", d, 32'd1);
    wr(0, R_SNAP, 32'd0);
    rd(0, R_SNAP, d); chk("t4_snap_frozen", d, 32'd2);
    idle(10);
    wr(0, R_SNAP, 32'd0);
    rd(0, R_SNAP, d); chk("t4_snap_still", d, 32'd2);

    // One-shot ch1, PERIOD=2, PRESCALE=3: single timeout 12 clocks after START.
    wr(1, R_PERIOD, 32'd2);
    idle(1);
    wr(1, R_PRESCALE, 32'd3);
    wr(1, R_CONTROL, 32'h5);
    idle(11); chk("t2_vec_before", 32'(irq_vec[1]), 32'd0);
    idle(1);  chk("t2_vec_timeout", 32'(irq_vec[1]), 32'd1);
    rd(1, R_STATUS, d); chk("t2_status_oneshot", d, 32'd1);
    wr(1, R_SNAP, 32'd0);
    rd(1, R_SNAP, d); chk("t2_snap_reload", d, 32'd2);

    // PWM on ch2, PERIOD=9: high for COMPARE of every 10 clocks.
    wr(2, R_PERIOD, 32'd9);
    wr(2, R_COMPARE, 32'd3);
    wr(2, R_CONTROL, 32'h16);
    idle(3);
    count_pwm(2, 20, k); chk("t3_pwm_duty3", 32'(k), 32'd6);
    wr(2, R_COMPARE, 32'd0);
    idle(2);
    count_pwm(2, 20, k); chk("t3_pwm_cmp0", 32'(k), 32'd0);
    wr(2, R_COMPARE, 32'd20);
    idle(2);
    count_pwm(2, 20, k); chk("t3_pwm_cmp20", 32'(k), 32'd20);

    // PERIOD write while running stops the channel and reloads the counter.
    wr(2, R_PERIOD, 32'd7);
    rd(2, R_STATUS, d); chk("t5_run_cleared", 32'((d >> 1) & 32'd1), 32'd0);
    wr(2, R_SNAP, 32'd0);
    rd(2, R_SNAP, d); chk("t5_cnt_reloaded", d, 32'd7);
    rd(2, R_PERIOD, d); chk("t5_period_rb", d, 32'd7);
    // Unpopulated channel slot 3: writes ignored, reads 0.
    wr(3, R_PERIOD, 32'd123);
    wr(3, R_CONTROL, 32'h7);
    rd(3, R_PERIOD, d); chk("t5_ch3_read0", d, 32'd0);
    rd(0, R_PERIOD, d); chk("t5_ch0_period", d, 32'd4);
    rd(1, R_PERIOD, d); chk("t5_ch1_period", d, 32'd2);
    rd(2, R_PERIOD, d); chk("t5_ch2_period", d, 32'd7);

    // All channels running, then an asynchronous reset mid-count.
    wr(0, R_COMPARE, 32'd3);
    wr(0, R_CONTROL, 32'h17);
    wr(1, R_CONTROL, 32'h7);
    wr(2, R_CONTROL, 32'h16);
    idle(2);
    chk("t6_pwm2_high", 32'(pwm_out[2]), 32'd1);
    idle(5);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_irq_async",   32'(irq),     32'd0);
    chk("t6_vec_async",   32'(irq_vec), 32'd0);
    chk("t6_pwm_async",   32'(pwm_out), 32'd0);
    chk("t6_rdata_async", bus.readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    rd(0, R_PERIOD, d);  chk("t6_period_rst", d, 32'd49999);
    rd(2, R_COMPARE, d); chk("t6_compare_rst", d, 32'd0);
    rd(1, R_STATUS, d);  chk("t6_status_rst", d, 32'd0);
    wr(0, R_SNAP, 32'd0);
    rd(0, R_SNAP, d);    chk("t6_cnt_rst", d, 32'd49999);
    idle(3);
    chk("t6_pwm_after", 32'(pwm_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
